// File: rtl/seq_div_pkg.sv
// Shared state type and width helper for the sequential restoring divider.
package seq_div_pkg;

    typedef enum logic [1:0] {IDLE, ITER, DONE} seq_div_state_t;

    // Iteration counter width: must hold WIDTH-1 with headroom.
    function automatic int seq_div_cw(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_div_datapath.sv
// Restoring-division datapath: R/Q/D registers, compare-subtract, iteration
// counter and result registers, sequenced by load/shift/capture strobes.
module seq_div_datapath
    import seq_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             capture,
    input  logic             capture_dz,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             last,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = seq_div_cw(WIDTH);

    // The partial remainder stays below D, so only the shifted value needs the extra bit.
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   d_ext;
    logic             ge;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] q_n;

    always_comb begin
        r_sh  = {r, q[WIDTH-1]};
        d_ext = {1'b0, d};
        ge    = (r_sh >= d_ext);
        r_n   = ge ? WIDTH'(r_sh - d_ext) : WIDTH'(r_sh);
        q_n   = {q[WIDTH-2:0], ge};
    end

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r         <= '0;
            q         <= '0;
            d         <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            if (load) begin
                r   <= '0;
                q   <= dividend;
                d   <= divisor;
                cnt <= '0;
            end else if (shift) begin
                r   <= r_n;
                q   <= q_n;
                cnt <= cnt + CW'(1);
            end
            // Results take the post-shift values of the final iteration.
            if (capture) begin
                quotient  <= q_n;
                remainder <= r_n;
            end else if (capture_dz) begin
                quotient  <= '1;
                remainder <= dividend;
            end
        end
    end

endmodule

// File: rtl/seq_div_ctrl.sv
// Iterative unsigned divider top: start/busy/done handshake FSM around the datapath.
// Optional early divide-by-zero exit enabled by defining SEQ_DIV_DZ_CHECK_EN.
module seq_div_ctrl
    import seq_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz
);

    seq_div_state_t state;
    logic accept;
    logic zero_div;
    logic load;
    logic shift;
    logic capture;
    logic capture_dz;
    logic last;
    logic dz_q;

    assign accept = (state != ITER) && start;

`ifdef SEQ_DIV_DZ_CHECK_EN
    assign zero_div = (divisor == '0);
`else
    assign zero_div = 1'b0;
`endif

    assign load       = accept && !zero_div;
    assign capture_dz = accept && zero_div;
    assign shift      = (state == ITER);
    assign capture    = shift && last;
    assign dz         = dz_q;

    seq_div_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .shift      (shift),
        .capture    (capture),
        .capture_dz (capture_dz),
        .dividend   (dividend),
        .divisor    (divisor),
        .last       (last),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            dz_q  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ITER: begin
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                // IDLE and DONE accept a new request identically.
                default: begin
                    if (accept) begin
                        dz_q <= zero_div;
                        if (zero_div) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ITER;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_ctrl.sv
// Self-checking bench for seq_div_ctrl: cycle model of the handshake plus directed and random divisions.
module tb_seq_div_ctrl;

    localparam int W = 8;
`ifdef SEQ_DIV_DZ_CHECK_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic         dz;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    seq_div_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: k counts edges since the last accepted start, lat is that op's latency.
    int           k = 0;
    int           lat = 0;
    logic [W-1:0] exp_q = '0;
    logic [W-1:0] exp_r = '0;
    logic [W-1:0] pend_q = '0;
    logic [W-1:0] pend_r = '0;
    logic         exp_dz = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                k = 0; lat = 0; exp_q = '0; exp_r = '0; exp_dz = 1'b0;
            end else begin
                if (!(k >= 1 && k < lat) && start) begin
                    if (divisor == '0) begin
                        pend_q = '1;
                        pend_r = dividend;
                    end else begin
                        pend_q = dividend / divisor;
                        pend_r = dividend % divisor;
                    end
                    lat    = (DZ_EN && divisor == '0) ? 1 : W + 1;
                    exp_dz = DZ_EN && (divisor == '0);
                    k      = 1;
                end else if (k >= 1 && k <= lat) begin
                    k++;
                end
                if (k >= 1 && k == lat) begin
                    exp_q = pend_q;
                    exp_r = pend_r;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("busy", busy, (k >= 1 && k < lat) ? 1 : 0);
                chk("done", done, (k >= 1 && k == lat) ? 1 : 0);
                chk("quotient", quotient, exp_q);
                chk("remainder", remainder, exp_r);
                chk("dz", dz, exp_dz);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Present a request now and hold it across exactly one rising edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; dividend = a; divisor = b;
        step();
        start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 40) begin
            step();
            n++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL wait_done: no done after %0d cycles", n);
        end
    endtask

    int n;
    int ndone;
    logic [W-1:0] a;
    logic [W-1:0] b;

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk_en = 1'b1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_q", quotient, 0);
        chk("reset_r", remainder, 0);
        chk("reset_dz", dz, 0);
        rst = 1'b1;
        step();

        step();
        issue(8'd100, 8'd7);
        chk("busy_c1_100_7", busy, 1);
        wait_done(n);
        chk("lat_100_7", n, 9);
        chk("q_100_7", quotient, 14);
        chk("r_100_7", remainder, 2);
        chk("dz_100_7", dz, 0);

        step();
        issue(8'd255, 8'd1);
        wait_done(n);
        chk("lat_255_1", n, 9);
        chk("q_255_1", quotient, 255);
        chk("r_255_1", remainder, 0);
        issue(8'd5, 8'd9);
        wait_done(n);
        chk("lat_b2b_5_9", n, 9);
        chk("q_5_9", quotient, 0);
        chk("r_5_9", remainder, 5);

        step(); step();
        issue(8'd0, 8'd3);
        step();
        start = 1'b1; dividend = 8'd77; divisor = 8'd2;
        step(); step(); step();
        start = 1'b0;
        ndone = 0;
        repeat (15) begin
            if (done) ndone++;
            step();
        end
        chk("stray_start_dones", ndone, 1);
        chk("q_0_3", quotient, 0);
        chk("r_0_3", remainder, 0);

        step();
        issue(8'd200, 8'd0);
        wait_done(n);
        chk("lat_200_0", n, DZ_EN ? 1 : 9);
        chk("q_200_0", quotient, 255);
        chk("r_200_0", remainder, 200);
        chk("dz_200_0", dz, DZ_EN ? 1 : 0);

        step();
        issue(8'd100, 8'd7);
        step(); step(); step();
        rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_q", quotient, 0);
        chk("arst_r", remainder, 0);
        chk("arst_dz", dz, 0);
        step(); step();
        rst = 1'b1;
        step();
        issue(8'd60, 8'd8);
        wait_done(n);
        chk("lat_60_8", n, 9);
        chk("q_60_8", quotient, 7);
        chk("r_60_8", remainder, 4);

        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 3)) step();
            a = W'($urandom);
            b = W'($urandom_range(1, 255));
            issue(a, b);
            wait_done(n);
            chk("rand_lat", n, 9);
            chk("rand_q", quotient, a / b);
            chk("rand_r", remainder, a % b);
        end

        repeat (4) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
